// File: rtl/trace_pkg.sv
// Shared state encoding and helpers for the trace_capture debug trace buffer.
`ifndef TRACE_PKG_SV
`define TRACE_PKG_SV

// Channel k of a flat probe vector made of w-bit channels.
`define TRACE_CH(vec, k, w) vec[(k)*(w) +: (w)]

package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_POST  = 2'd2,
    ST_DRAIN = 2'd3
  } trace_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`endif

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port with read enable.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64,
  localparam int AW   = ptr_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // The read register only updates on i_rd_en so the consumer can stall it.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/trace_capture.sv
// On-chip CPU trace buffer: circular capture around a trigger, frozen, then streamed oldest-first.
// Optional macro TRACE_COMPARE_EN adds a probe vs exp_data mismatch counter on err_cnt.
module trace_capture
  import trace_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 16,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   sample_en,
  input  logic [NUM_CH*CH_W-1:0] probe,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [CH_W-1:0]        trig_value,
  input  logic                   force_trig,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [NUM_CH*CH_W-1:0] rd_data,
  output logic                   rd_last,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            err_cnt,
  input  logic [NUM_CH*CH_W-1:0] exp_data
);

  localparam int W  = NUM_CH * CH_W;
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] FILL_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] POST_LOAD = (PW+1)'(POST_TRIG);
  localparam logic [PW:0] ONE_CNT   = (PW+1)'(1);

  trace_state_e r_state;
  trace_state_e w_state_next;

  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_fill;
  logic [PW:0]   r_post_cnt;
  logic [PW:0]   r_rd_cnt;
  logic          r_s1_vld;
  logic          r_s1_last;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic [W-1:0]  r_rd_data;

  logic          w_capturing;
  logic          w_we;
  logic          w_trig;
  logic [PW-1:0] w_wr_addr;
  logic [PW-1:0] w_rd_start;
  logic [PW-1:0] w_rd_addr;
  logic          w_out_rdy;
  logic          w_issue;
  logic          w_accept;
  logic          w_last_acc;
  logic [W-1:0]  w_ram_q;

  assign w_capturing = (r_state == ST_PRE) || (r_state == ST_POST);
  // An arm pulse with a sample makes that sample entry 0 of the new trace.
  assign w_we        = sample_en && (arm || w_capturing);
  assign w_wr_addr   = arm ? '0 : r_wr_ptr;
  assign w_trig      = sample_en &&
                       (force_trig || (trig_en && (`TRACE_CH(probe, 0, CH_W) == trig_value)));

  always_comb begin
    w_state_next = r_state;
    if (arm) begin
      w_state_next = ST_PRE;
    end else begin
      case (r_state)
        ST_PRE: begin
          if (w_trig) begin
            w_state_next = (POST_TRIG == 0) ? ST_DRAIN : ST_POST;
          end
        end
        ST_POST: begin
          if (sample_en && (r_post_cnt == ONE_CNT)) begin
            w_state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_last_acc) begin
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  // Readout is a two-stage pipe (RAM register, output register) with a shared stall.
  assign w_rd_start = (r_fill == FILL_FULL) ? r_wr_ptr : '0;
  assign w_rd_addr  = w_rd_start + r_rd_cnt[PW-1:0];
  assign w_out_rdy  = !r_rd_valid || rd_ready;
  assign w_issue    = (r_state == ST_DRAIN) && !arm && (r_rd_cnt != r_fill) &&
                      (!r_s1_vld || w_out_rdy);
  assign w_accept   = r_rd_valid && rd_ready;
  assign w_last_acc = w_accept && r_rd_last;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_post_cnt <= '0;
      r_rd_cnt   <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state <= w_state_next;

      if (arm) begin
        r_wr_ptr <= sample_en ? PW'(1) : '0;
        r_fill   <= sample_en ? ONE_CNT : '0;
      end else if (w_we) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (r_fill != FILL_FULL) begin
          r_fill <= r_fill + ONE_CNT;
        end
      end

      if (arm) begin
        r_post_cnt <= '0;
      end else if ((r_state == ST_PRE) && w_trig) begin
        r_post_cnt <= POST_LOAD;
      end else if ((r_state == ST_POST) && sample_en) begin
        r_post_cnt <= r_post_cnt - ONE_CNT;
      end

      if (arm || (r_state != ST_DRAIN)) begin
        r_rd_cnt <= '0;
        r_s1_vld <= 1'b0;
      end else if (w_issue) begin
        r_rd_cnt  <= r_rd_cnt + ONE_CNT;
        r_s1_vld  <= 1'b1;
        r_s1_last <= ((r_rd_cnt + ONE_CNT) == r_fill);
      end else if (w_out_rdy) begin
        r_s1_vld <= 1'b0;
      end

      if (arm || (r_state != ST_DRAIN) || w_last_acc) begin
        r_rd_valid <= 1'b0;
      end else if (w_out_rdy) begin
        r_rd_valid <= r_s1_vld;
        if (r_s1_vld) begin
          r_rd_data <= w_ram_q;
          r_rd_last <= r_s1_last;
        end
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_ram (
    .i_clk     (Clk),
    .i_wr_en   (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (probe),
    .i_rd_en   (w_issue),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_last  = r_rd_valid && r_rd_last;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DRAIN);

`ifdef TRACE_COMPARE_EN
  logic [NUM_CH-1:0] w_ch_diff;
  logic              w_mismatch;
  logic [15:0]       r_err_cnt;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cmp
    assign w_ch_diff[gi] = (`TRACE_CH(probe, gi, CH_W) != `TRACE_CH(exp_data, gi, CH_W));
  end

  // Only samples taken while already capturing are compared; arm just clears.
  assign w_mismatch = sample_en && w_capturing && !arm && (|w_ch_diff);

  always_ff @(posedge Clk) begin
    if (reset || arm) begin
      r_err_cnt <= '0;
    end else if (w_mismatch && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_exp;
  assign w_unused_exp = ^exp_data;
  assign err_cnt      = '0;
`endif

endmodule
